// File: rtl/reg_rd_if.sv
// rtl/reg_rd_if.sv - operand read request/response bundle between consumer and reg_rd
interface reg_rd_if #(
  parameter int W = 16
);
  logic         start;
  logic [2:0]   rs_a;
  logic [2:0]   rs_b;
  logic         ack;
  logic         busy;
  logic         valid;
  logic [W-1:0] opr_a;
  logic [W-1:0] opr_b;
  logic [7:0]   n_read;

  modport master (
    output start, rs_a, rs_b, ack,
    input  busy, valid, opr_a, opr_b, n_read
  );

  modport slave (
    input  start, rs_a, rs_b, ack,
    output busy, valid, opr_a, opr_b, n_read
  );
endinterface

// File: rtl/reg_rd.sv
// rtl/reg_rd.sv - register-file operand reader with write-back bypass and hold/ack handshake
module reg_rd #(
  parameter int W = 16
) (
  input  logic         clk_rd,
  input  logic         reset,
  reg_rd_if.slave      rd,
  input  logic [W-1:0] reg0,
  input  logic [W-1:0] reg1,
  input  logic [W-1:0] reg2,
  input  logic [W-1:0] reg3,
  input  logic [W-1:0] reg4,
  input  logic [W-1:0] reg5,
  input  logic [W-1:0] reg6,
  input  logic [W-1:0] reg7,
  input  logic         wb_en,
  input  logic [2:0]   wb_n_reg,
  input  logic [W-1:0] wb_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [2:0]   idx_a;
  logic [2:0]   idx_b;
  logic [W-1:0] opr_a_q;
  logic [W-1:0] opr_b_q;
  logic [7:0]   n_read_q;
  logic [W-1:0] regs [8];
  logic         hit_a;
  logic         hit_b;

  assign regs[0] = reg0;
  assign regs[1] = reg1;
  assign regs[2] = reg2;
  assign regs[3] = reg3;
  assign regs[4] = reg4;
  assign regs[5] = reg5;
  assign regs[6] = reg6;
  assign regs[7] = reg7;

  // A write-back landing on a latched source index overrides the stale file value.
  assign hit_a = wb_en && (wb_n_reg == idx_a);
  assign hit_b = wb_en && (wb_n_reg == idx_b);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd.start) state_d = READ;
      READ:    state_d = HOLD;
      HOLD:    if (rd.ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_rd) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_a    <= 3'd0;
      idx_b    <= 3'd0;
      opr_a_q  <= '0;
      opr_b_q  <= '0;
      n_read_q <= 8'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (rd.start) begin
            idx_a <= rd.rs_a;
            idx_b <= rd.rs_b;
          end
        end
        READ: begin
          opr_a_q <= hit_a ? wb_data : regs[idx_a];
          opr_b_q <= hit_b ? wb_data : regs[idx_b];
        end
        HOLD: begin
          // ack retires the read; a coincident write-back is not folded in.
          if (rd.ack) begin
            n_read_q <= n_read_q + 8'd1;
          end else begin
            if (hit_a) opr_a_q <= wb_data;
            if (hit_b) opr_b_q <= wb_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd.busy   = (state_q != IDLE);
  assign rd.valid  = (state_q == HOLD);
  assign rd.opr_a  = opr_a_q;
  assign rd.opr_b  = opr_b_q;
  assign rd.n_read = n_read_q;

endmodule

// File: tb/tb_reg_rd.sv
// tb/tb_reg_rd.sv - self-checking bench for reg_rd with randomized transactions and reference model
module tb_reg_rd;

  logic        clk_rd = 1'b0;
  logic        reset;
  logic [15:0] rf [8];
  logic        wb_en;
  logic [2:0]  wb_n_reg;
  logic [15:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_reads = 0;

  reg_rd_if #(.W(16)) rd_bus ();

  reg_rd #(.W(16)) dut (
    .clk_rd   (clk_rd),
    .reset    (reset),
    .rd       (rd_bus),
    .reg0     (rf[0]),
    .reg1     (rf[1]),
    .reg2     (rf[2]),
    .reg3     (rf[3]),
    .reg4     (rf[4]),
    .reg5     (rf[5]),
    .reg6     (rf[6]),
    .reg7     (rf[7]),
    .wb_en    (wb_en),
    .wb_n_reg (wb_n_reg),
    .wb_data  (wb_data)
  );

  always #5 clk_rd = ~clk_rd;

  task automatic step();
    @(posedge clk_rd);
    @(negedge clk_rd);
  endtask

  task automatic randomize_rf();
    for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
  endtask

  // Drives start for one edge, then the READ-cycle write-back; ends with the DUT in HOLD.
  task automatic issue(input logic [2:0] ra, input logic [2:0] rb,
                       input logic we, input logic [2:0] wr, input logic [15:0] wd);
    rd_bus.start = 1'b1;
    rd_bus.rs_a  = ra;
    rd_bus.rs_b  = rb;
    step();
    rd_bus.start = 1'b0;
    rd_bus.rs_a  = 3'($urandom);
    rd_bus.rs_b  = 3'($urandom);
    wb_en    = we;
    wb_n_reg = wr;
    wb_data  = wd;
    step();
    wb_en = 1'b0;
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] idx, input logic we,
                                             input logic [2:0] wr, input logic [15:0] wd);
    return (we && wr == idx) ? wd : rf[idx];
  endfunction

  task automatic test_reset();
    rd_bus.start = 1'b1;
    rd_bus.ack   = 1'b1;
    wb_en        = 1'b1;
    reset        = 1'b1;
    step();
    step();
    rd_bus.start = 1'b0;
    rd_bus.ack   = 1'b0;
    wb_en        = 1'b0;
    reset        = 1'b0;
    exp_reads    = 0;
    n_checks++;
    if (rd_bus.busy !== 1'b0 || rd_bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%b valid=%b required 0 0", rd_bus.busy, rd_bus.valid);
    end
    n_checks++;
    if (rd_bus.opr_a !== 16'h0 || rd_bus.opr_b !== 16'h0 || rd_bus.n_read !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_data: opr_a=%h opr_b=%h n_read=%0d required 0 0 0",
               rd_bus.opr_a, rd_bus.opr_b, rd_bus.n_read);
    end
  endtask

  task automatic test_basic();
    randomize_rf();
    rf[2] = 16'h1234;
    rf[5] = 16'hABCD;
    rd_bus.start = 1'b1;
    rd_bus.rs_a  = 3'd2;
    rd_bus.rs_b  = 3'd5;
    step();
    rd_bus.start = 1'b0;
    n_checks++;
    if (rd_bus.busy !== 1'b1 || rd_bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_read_phase: busy=%b valid=%b required 1 0", rd_bus.busy, rd_bus.valid);
    end
    step();
    n_checks++;
    if (rd_bus.valid !== 1'b1 || rd_bus.opr_a !== 16'h1234 || rd_bus.opr_b !== 16'hABCD) begin
      n_fail++;
      $display("FAIL basic_hold: valid=%b opr_a=%h opr_b=%h required 1 1234 abcd",
               rd_bus.valid, rd_bus.opr_a, rd_bus.opr_b);
    end
    rd_bus.ack = 1'b1;
    step();
    rd_bus.ack = 1'b0;
    exp_reads++;
    n_checks++;
    if (rd_bus.valid !== 1'b0 || rd_bus.n_read !== 8'(exp_reads)) begin
      n_fail++;
      $display("FAIL basic_ack: valid=%b n_read=%0d required 0 %0d",
               rd_bus.valid, rd_bus.n_read, exp_reads);
    end
  endtask

  task automatic test_bypass_read();
    randomize_rf();
    issue(3'd5, 3'd5, 1'b1, 3'd5, 16'h0F0F);
    n_checks++;
    if (rd_bus.opr_a !== 16'h0F0F || rd_bus.opr_b !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL bypass_read: opr_a=%h opr_b=%h required 0f0f 0f0f", rd_bus.opr_a, rd_bus.opr_b);
    end
    rd_bus.ack = 1'b1;
    step();
    rd_bus.ack = 1'b0;
    exp_reads++;
  endtask

  task automatic test_hold_refresh();
    logic [15:0] eb;
    randomize_rf();
    eb = rf[1];
    issue(3'd3, 3'd1, 1'b0, 3'd0, 16'h0);
    wb_en = 1'b0; wb_n_reg = 3'd3; wb_data = 16'hFFFF;
    step();
    n_checks++;
    if (rd_bus.opr_a !== rf[3]) begin
      n_fail++;
      $display("FAIL hold_wb_disabled: opr_a=%h required %h", rd_bus.opr_a, rf[3]);
    end
    wb_en = 1'b1; wb_n_reg = 3'd3; wb_data = 16'h5555; rd_bus.ack = 1'b0;
    step();
    n_checks++;
    if (rd_bus.opr_a !== 16'h5555 || rd_bus.opr_b !== eb || rd_bus.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_refresh: opr_a=%h opr_b=%h valid=%b required 5555 %h 1",
               rd_bus.opr_a, rd_bus.opr_b, rd_bus.valid, eb);
    end
    wb_data = 16'hAAAA; rd_bus.ack = 1'b1;
    step();
    wb_en = 1'b0; rd_bus.ack = 1'b0;
    exp_reads++;
    n_checks++;
    if (rd_bus.opr_a !== 16'h5555 || rd_bus.busy !== 1'b0 || rd_bus.n_read !== 8'(exp_reads)) begin
      n_fail++;
      $display("FAIL hold_ack_priority: opr_a=%h busy=%b n_read=%0d required 5555 0 %0d",
               rd_bus.opr_a, rd_bus.busy, rd_bus.n_read, exp_reads);
    end
  endtask

  task automatic test_start_held();
    randomize_rf();
    rd_bus.start = 1'b1; rd_bus.rs_a = 3'd1; rd_bus.rs_b = 3'd2;
    step();
    step();
    rd_bus.ack = 1'b1;
    step();
    rd_bus.ack = 1'b0;
    exp_reads++;
    n_checks++;
    if (rd_bus.busy !== 1'b0 || rd_bus.n_read !== 8'(exp_reads)) begin
      n_fail++;
      $display("FAIL start_held_idle: busy=%b n_read=%0d required 0 %0d",
               rd_bus.busy, rd_bus.n_read, exp_reads);
    end
    step();
    n_checks++;
    if (rd_bus.busy !== 1'b1 || rd_bus.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_held_reissue: busy=%b valid=%b required 1 0", rd_bus.busy, rd_bus.valid);
    end
    rd_bus.start = 1'b0;
    step();
    rd_bus.ack = 1'b1;
    step();
    rd_bus.ack = 1'b0;
    exp_reads++;
    n_checks++;
    if (rd_bus.n_read !== 8'(exp_reads)) begin
      n_fail++;
      $display("FAIL start_held_count: n_read=%0d required %0d", rd_bus.n_read, exp_reads);
    end
  endtask

  task automatic test_ignore();
    logic [15:0] ea;
    rd_bus.ack = 1'b1;
    step();
    rd_bus.ack = 1'b0;
    n_checks++;
    if (rd_bus.busy !== 1'b0 || rd_bus.n_read !== 8'(exp_reads)) begin
      n_fail++;
      $display("FAIL ack_in_idle: busy=%b n_read=%0d required 0 %0d",
               rd_bus.busy, rd_bus.n_read, exp_reads);
    end
    randomize_rf();
    ea = rf[4];
    issue(3'd4, 3'd6, 1'b0, 3'd0, 16'h0);
    rd_bus.start = 1'b1; rd_bus.rs_a = 3'd0;
    step();
    step();
    rd_bus.start = 1'b0;
    n_checks++;
    if (rd_bus.valid !== 1'b1 || rd_bus.opr_a !== ea || rd_bus.n_read !== 8'(exp_reads)) begin
      n_fail++;
      $display("FAIL start_in_hold: valid=%b opr_a=%h n_read=%0d required 1 %h %0d",
               rd_bus.valid, rd_bus.opr_a, rd_bus.n_read, ea, exp_reads);
    end
    rd_bus.ack = 1'b1;
    step();
    rd_bus.ack = 1'b0;
    exp_reads++;
  endtask

  task automatic test_random();
    logic [2:0]  ra, rb, wr;
    logic        we, st;
    logic [15:0] wd, ea, eb;
    int          hold_cycles;
    for (int t = 0; t < 60; t++) begin
      randomize_rf();
      ra = 3'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom);
      we = 1'($urandom);
      wr = ($urandom_range(0, 1) == 0) ? ra : 3'($urandom);
      wd = 16'($urandom);
      ea = model_read(ra, we, wr, wd);
      eb = model_read(rb, we, wr, wd);
      issue(ra, rb, we, wr, wd);
      n_checks++;
      if (rd_bus.valid !== 1'b1 || rd_bus.opr_a !== ea || rd_bus.opr_b !== eb) begin
        n_fail++;
        $display("FAIL rand_read[%0d]: valid=%b opr_a=%h opr_b=%h required 1 %h %h",
                 t, rd_bus.valid, rd_bus.opr_a, rd_bus.opr_b, ea, eb);
      end
      hold_cycles = $urandom_range(0, 3);
      for (int h = 0; h < hold_cycles; h++) begin
        wb_en        = 1'($urandom);
        wb_n_reg     = ($urandom_range(0, 1) == 0) ? rb : 3'($urandom);
        wb_data      = 16'($urandom);
        rd_bus.start = 1'($urandom);
        step();
        if (wb_en && wb_n_reg == ra) ea = wb_data;
        if (wb_en && wb_n_reg == rb) eb = wb_data;
        n_checks++;
        if (rd_bus.valid !== 1'b1 || rd_bus.opr_a !== ea || rd_bus.opr_b !== eb) begin
          n_fail++;
          $display("FAIL rand_hold[%0d.%0d]: valid=%b opr_a=%h opr_b=%h required 1 %h %h",
                   t, h, rd_bus.valid, rd_bus.opr_a, rd_bus.opr_b, ea, eb);
        end
      end
      st           = 1'($urandom);
      wb_en        = 1'($urandom);
      wb_n_reg     = ra;
      wb_data      = 16'($urandom);
      rd_bus.start = st;
      rd_bus.ack   = 1'b1;
      step();
      rd_bus.start = 1'b0;
      rd_bus.ack   = 1'b0;
      wb_en        = 1'b0;
      exp_reads++;
      n_checks++;
      if (rd_bus.busy !== 1'b0 || rd_bus.opr_a !== ea || rd_bus.opr_b !== eb ||
          rd_bus.n_read !== 8'(exp_reads % 256)) begin
        n_fail++;
        $display("FAIL rand_ack[%0d]: busy=%b opr_a=%h opr_b=%h n_read=%0d required 0 %h %h %0d",
                 t, rd_bus.busy, rd_bus.opr_a, rd_bus.opr_b, rd_bus.n_read, ea, eb, exp_reads % 256);
      end
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_reads = 0;
    for (int i = 0; i < 256; i++) begin
      issue(3'($urandom), 3'($urandom), 1'b0, 3'd0, 16'h0);
      rd_bus.ack = 1'b1;
      step();
      rd_bus.ack = 1'b0;
      exp_reads++;
      if (i == 254) begin
        n_checks++;
        if (rd_bus.n_read !== 8'd255) begin
          n_fail++;
          $display("FAIL wrap_255: n_read=%0d required 255", rd_bus.n_read);
        end
      end
    end
    n_checks++;
    if (rd_bus.n_read !== 8'(exp_reads % 256)) begin
      n_fail++;
      $display("FAIL wrap_0: n_read=%0d required %0d", rd_bus.n_read, exp_reads % 256);
    end
  endtask

  task automatic test_reset_in_hold();
    issue(3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
    issue(3'd0, 3'd0, 1'b0, 3'd0, 16'h0);
    rf[3] = 16'hBEEF;
    rf[6] = 16'hCAFE;
    rd_bus.ack = 1'b1;
    step();
    rd_bus.ack = 1'b0;
    issue(3'd3, 3'd6, 1'b0, 3'd0, 16'h0);
    rd_bus.ack = 1'b1;
    reset      = 1'b1;
    step();
    reset      = 1'b0;
    rd_bus.ack = 1'b0;
    exp_reads  = 0;
    n_checks++;
    if (rd_bus.valid !== 1'b0 || rd_bus.busy !== 1'b0 || rd_bus.opr_a !== 16'h0 ||
        rd_bus.opr_b !== 16'h0 || rd_bus.n_read !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_in_hold: valid=%b busy=%b opr_a=%h opr_b=%h n_read=%0d required 0 0 0 0 0",
               rd_bus.valid, rd_bus.busy, rd_bus.opr_a, rd_bus.opr_b, rd_bus.n_read);
    end
  endtask

  initial begin
    reset        = 1'b1;
    rd_bus.start = 1'b0;
    rd_bus.ack   = 1'b0;
    rd_bus.rs_a  = 3'd0;
    rd_bus.rs_b  = 3'd0;
    wb_en        = 1'b0;
    wb_n_reg     = 3'd0;
    wb_data      = 16'h0;
    randomize_rf();
    @(negedge clk_rd);
    test_reset();
    test_basic();
    test_bypass_read();
    test_hold_refresh();
    test_start_held();
    test_ignore();
    test_random();
    test_wrap();
    test_reset_in_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
